// File: rtl/decoder_8b10b_rx.sv
// decoder_8b10b_rx: 8b/10b receive decoder with RD tracking and code/disparity/comma flags; define DECODER_ERR_CNT_EN for ErrCount/ErrCountClr
module decoder_8b10b_rx #(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 BitCLK_10,
  input  logic                 Reset,
  input  logic [9:0]           RxParallel_10,
  input  logic                 RxValid,
  output logic [7:0]           RxParallel_8,
  output logic                 RxDataK,
  output logic                 DataValid,
  output logic                 CodeErr,
  output logic                 DispErr,
  output logic                 CommaDet,
  output logic                 RdOut
`ifdef DECODER_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] ErrCount,
  input  logic                 ErrCountClr
`endif
);
  function automatic logic [5:0] dec6(input logic [5:0] s);
    case (s)
      6'b100111, 6'b011000: dec6 = {1'b1, 5'd0};
      6'b011101, 6'b100010: dec6 = {1'b1, 5'd1};
      6'b101101, 6'b010010: dec6 = {1'b1, 5'd2};
      6'b110001:            dec6 = {1'b1, 5'd3};
      6'b110101, 6'b001010: dec6 = {1'b1, 5'd4};
      6'b101001:            dec6 = {1'b1, 5'd5};
      6'b011001:            dec6 = {1'b1, 5'd6};
      6'b111000, 6'b000111: dec6 = {1'b1, 5'd7};
      6'b111001, 6'b000110: dec6 = {1'b1, 5'd8};
      6'b100101:            dec6 = {1'b1, 5'd9};
      6'b010101:            dec6 = {1'b1, 5'd10};
      6'b110100:            dec6 = {1'b1, 5'd11};
      6'b001101:            dec6 = {1'b1, 5'd12};
      6'b101100:            dec6 = {1'b1, 5'd13};
      6'b011100:            dec6 = {1'b1, 5'd14};
      6'b010111, 6'b101000: dec6 = {1'b1, 5'd15};
      6'b011011, 6'b100100: dec6 = {1'b1, 5'd16};
      6'b100011:            dec6 = {1'b1, 5'd17};
      6'b010011:            dec6 = {1'b1, 5'd18};
      6'b110010:            dec6 = {1'b1, 5'd19};
      6'b001011:            dec6 = {1'b1, 5'd20};
      6'b101010:            dec6 = {1'b1, 5'd21};
      6'b011010:            dec6 = {1'b1, 5'd22};
      6'b111010, 6'b000101: dec6 = {1'b1, 5'd23};
      6'b110011, 6'b001100: dec6 = {1'b1, 5'd24};
      6'b100110:            dec6 = {1'b1, 5'd25};
      6'b010110:            dec6 = {1'b1, 5'd26};
      6'b110110, 6'b001001: dec6 = {1'b1, 5'd27};
      6'b001110, 6'b001111, 6'b110000: dec6 = {1'b1, 5'd28};
      6'b101110, 6'b010001: dec6 = {1'b1, 5'd29};
      6'b011110, 6'b100001: dec6 = {1'b1, 5'd30};
      6'b101011, 6'b010100: dec6 = {1'b1, 5'd31};
      default:              dec6 = 6'd0;
    endcase
  endfunction
  function automatic logic [3:0] dec4(input logic [3:0] s);
    case (s)
      4'b0100, 4'b1011: dec4 = {1'b1, 3'd0};
      4'b1001:          dec4 = {1'b1, 3'd1};
      4'b0101:          dec4 = {1'b1, 3'd2};
      4'b0011, 4'b1100: dec4 = {1'b1, 3'd3};
      4'b0010, 4'b1101: dec4 = {1'b1, 3'd4};
      4'b1010:          dec4 = {1'b1, 3'd5};
      4'b0110:          dec4 = {1'b1, 3'd6};
      4'b0001, 4'b1110, 4'b0111, 4'b1000: dec4 = {1'b1, 3'd7};
      default:          dec4 = 4'd0;
    endcase
  endfunction
  logic [5:0] six, d6;
  logic [3:0] fghj, fx, d4;
  logic [2:0] p6, p4;
  logic k28, k28_ok, kx7, a7, a7_ok, rd_mid, rd_nxt, code_err, disp_err, is_k, comma;
  assign six  = RxParallel_10[5:0];
  assign fghj = RxParallel_10[9:6];
  assign p6   = 3'($countones(six));
  assign p4   = 3'($countones(fghj));
  assign k28  = six inside {6'b001111, 6'b110000};
  // K28 at RD+ carries complemented fghj relative to the data table
  assign fx   = six == 6'b110000 ? ~fghj : fghj;
  assign d6   = dec6(six);
  assign d4   = dec4(fx);
  assign k28_ok = fx inside {4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
  assign a7   = fghj inside {4'b0111, 4'b1000};
  assign kx7  = a7 && (six inside {6'b111010, 6'b000101, 6'b110110, 6'b001001,
                                   6'b101110, 6'b010001, 6'b011110, 6'b100001});
  assign rd_mid = p6 > 3'd3 ? 1'b1 : p6 < 3'd3 ? 1'b0 : RdOut;
  assign rd_nxt = p4 > 3'd2 ? 1'b1 : p4 < 3'd2 ? 1'b0 : rd_mid;
  assign a7_ok = kx7 || k28
              || (fghj == 4'b0111 && !rd_mid && d6[4:0] inside {5'd17, 5'd18, 5'd20})
              || (fghj == 4'b1000 &&  rd_mid && d6[4:0] inside {5'd11, 5'd13, 5'd14});
  assign code_err = !d6[5] || !d4[3] || (k28 && !k28_ok) || (a7 && !a7_ok);
  assign disp_err = (p6 > 3'd3 && RdOut) || (p6 < 3'd3 && !RdOut)
                 || (p4 > 3'd2 && rd_mid) || (p4 < 3'd2 && !rd_mid)
                 || (six == 6'b111000 && RdOut) || (six == 6'b000111 && !RdOut)
                 || (fghj == 4'b1100 && rd_mid) || (fghj == 4'b0011 && !rd_mid);
  assign is_k  = (k28 && k28_ok) || kx7;
  assign comma = k28 && (fx inside {4'b1001, 4'b1010, 4'b1000});
  always_ff @(posedge BitCLK_10) begin
    if (!Reset) begin
      RxParallel_8 <= '0;
      RxDataK      <= 1'b0;
      DataValid    <= 1'b0;
      CodeErr      <= 1'b0;
      DispErr      <= 1'b0;
      CommaDet     <= 1'b0;
      RdOut        <= 1'b0;
    end else begin
      DataValid <= RxValid;
      if (RxValid) begin
        RxParallel_8 <= {d4[3] ? d4[2:0] : 3'd0, d6[5] ? d6[4:0] : 5'd0};
        RxDataK      <= is_k;
        CodeErr      <= code_err;
        DispErr      <= disp_err;
        CommaDet     <= comma;
        RdOut        <= rd_nxt;
      end
    end
  end
`ifdef DECODER_ERR_CNT_EN
  always_ff @(posedge BitCLK_10) begin
    if (!Reset || ErrCountClr)
      ErrCount <= '0;
    else if (RxValid && (code_err || disp_err) && !(&ErrCount))
      ErrCount <= ErrCount + ERR_CNT_W'(1);
  end
`endif
endmodule

// File: tb/tb_decoder_8b10b_rx.sv
// tb_decoder_8b10b_rx: directed vectors with a queue scoreboard for decoder_8b10b_rx
module tb_decoder_8b10b_rx;
  typedef struct packed {
    logic [7:0]  d;
    logic        k, c, e, m, r;
    logic [15:0] n;
  } exp_t;
  logic clk = 0, rst_n = 0, vld = 0;
  logic [9:0] din = '0;
  logic [7:0] dout;
  logic k, dv, cerr, derr, comma, rd;
  int checks = 0, failures = 0;
  exp_t q[$];
  exp_t mon_e;
  logic [15:0] exp_cnt = '0;
  logic exp_dv = 0, in_rst = 1;
`ifdef DECODER_ERR_CNT_EN
  logic [15:0] cnt;
  logic clr = 0;
`endif
  always #5 clk = ~clk;
  decoder_8b10b_rx dut (
    .BitCLK_10(clk), .Reset(rst_n), .RxParallel_10(din), .RxValid(vld),
    .RxParallel_8(dout), .RxDataK(k), .DataValid(dv), .CodeErr(cerr),
    .DispErr(derr), .CommaDet(comma), .RdOut(rd)
`ifdef DECODER_ERR_CNT_EN
    , .ErrCount(cnt), .ErrCountClr(clr)
`endif
  );
  always @(posedge clk) begin
    exp_dv <= rst_n && vld;
    in_rst <= !rst_n;
  end
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    chk("data_valid", {15'd0, dv}, {15'd0, exp_dv});
    if (in_rst) begin
      chk("rst_byte", {8'd0, dout}, 16'd0);
      chk("rst_flags", {11'd0, k, cerr, derr, comma, rd}, 16'd0);
    end
    if (dv) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%h expected=none", dout);
      end else begin
        mon_e = q.pop_front();
        chk("byte", {8'd0, dout}, {8'd0, mon_e.d});
        chk("k_flag", {15'd0, k}, {15'd0, mon_e.k});
        chk("code_err", {15'd0, cerr}, {15'd0, mon_e.c});
        chk("disp_err", {15'd0, derr}, {15'd0, mon_e.e});
        chk("comma", {15'd0, comma}, {15'd0, mon_e.m});
        chk("rd_out", {15'd0, rd}, {15'd0, mon_e.r});
`ifdef DECODER_ERR_CNT_EN
        chk("err_count", cnt, mon_e.n);
`endif
      end
    end
  end
  task automatic send(input logic [9:0] code, input logic [7:0] d,
                      input logic kk, c, e, m, r);
    din = code;
    vld = 1;
    if ((c || e) && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    q.push_back('{d, kk, c, e, m, r, exp_cnt});
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    vld = 0;
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    send(10'h127, 8'h00, 0, 0, 0, 0, 0);
    send(10'h28F, 8'hBC, 1, 0, 0, 1, 1);
    send(10'h170, 8'hBC, 1, 0, 0, 1, 0);
    send(10'h170, 8'hBC, 1, 0, 1, 1, 0);
    send(10'h000, 8'h00, 0, 1, 1, 0, 0);
`ifdef DECODER_ERR_CNT_EN
    clr = 1;
    din = 10'h000;
    vld = 1;
    exp_cnt = '0;
    q.push_back('{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, exp_cnt});
    @(posedge clk);
    #1;
    clr = 0;
`endif
    send(10'h2AA, 8'hB5, 0, 0, 0, 0, 0);
    send(10'h20F, 8'hFC, 1, 0, 0, 1, 0);
    send(10'h1E3, 8'hF1, 0, 0, 0, 0, 1);
    send(10'h234, 8'hEB, 0, 0, 0, 0, 0);
    send(10'h21D, 8'hE1, 0, 1, 0, 0, 0);
    send(10'h23A, 8'hF7, 1, 0, 0, 0, 0);
    send(10'h2CF, 8'h1C, 0, 1, 1, 0, 1);
    send(10'h2D8, 8'h00, 0, 0, 0, 0, 1);
    send(10'h178, 8'h47, 0, 0, 1, 0, 1);
    send(10'h170, 8'hBC, 1, 0, 0, 1, 0);
    idle();
    send(10'h127, 8'h00, 0, 0, 0, 0, 0);
    idle();
    send(10'h28F, 8'hBC, 1, 0, 0, 1, 1);
    idle();
    din = 10'h28F;
    vld = 1;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    exp_cnt = '0;
    rst_n = 1;
    send(10'h28F, 8'hBC, 1, 0, 0, 1, 1);
    idle();
    idle();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain actual=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
